snoop_arbiter: RTL and testbench
================================

SNOOP_ARBITER -- requirements
Module: snoop_arbiter

Interface
REQ-001 SHALL have parameter NUM_NODES, default NUM_CACHE, number of bus requesters.
REQ-002 SHALL have parameter TIMEOUT, default SNOOP_TIMEOUT, maximum WAIT cycles before forced release.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_NODES  per-node level bus request, held by the requester until its gnt bit is seen.
REQ-006 SHALL have port done  input  1  one-cycle pulse: granted transaction complete, bus released.
REQ-007 SHALL have port gnt  output  NUM_NODES  registered one-hot0 grant, one-cycle pulse, feeds the snoop bus mux.
REQ-008 SHALL have port busy  output  1  high while state is GRANT or WAIT.
REQ-009 SHALL have port owner  output  $clog2(NUM_NODES)  index of the most recent grant.
REQ-010 SHALL have port timeout  output  1  sticky error flag, set on WAIT expiry, cleared only by rst.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT and WAIT.
REQ-012 SHALL in IDLE with req != 0 select winner w = first set req bit strictly after ptr, circular order (ptr+1 ... NUM_NODES-1, 0 ... ptr), and go to GRANT.
REQ-013 SHALL in GRANT drive gnt = one-hot(w) for exactly one cycle, set owner = w and ptr = w, clear the WAIT counter, then go to WAIT.
REQ-014 SHALL have latency req sampled high in IDLE at cycle N -> gnt high in cycle N+1.
REQ-015 SHALL hold gnt = 0 in IDLE and WAIT; gnt SHALL never have more than one bit set.
REQ-016 SHALL in WAIT go to IDLE on done; the earliest next gnt is then 2 cycles after done.
REQ-017 SHALL in GRANT treat done high as completion and go directly to IDLE.
REQ-018 SHALL ignore done in IDLE.
REQ-019 SHALL count WAIT cycles with a counter of width $clog2(TIMEOUT+1); when the count reaches TIMEOUT without done, it SHALL set timeout and go to IDLE.
REQ-020 SHALL give done priority over timeout when both occur in the same cycle; timeout is then not set.
REQ-021 SHALL not revoke a grant if the winning req deasserts after selection; gnt still pulses.
REQ-022 SHALL grant a lone requester repeatedly, with ptr = its own index.
REQ-023 SHALL, with all req held high, grant nodes in order 0,1,...,NUM_NODES-1,0 starting from reset.

Reset
REQ-024 SHALL on rst set state IDLE, gnt 0, busy 0, owner 0, timeout 0, WAIT counter 0, ptr NUM_NODES-1 so that node 0 wins first.
REQ-025 SHALL let rst asserted in GRANT or WAIT abort the transaction, with gnt 0 from the next cycle.
REQ-026 SHALL give rst priority over every input.

Structure
REQ-027 SHALL define arb_state_t (IDLE/GRANT/WAIT) and the constant SNOOP_TIMEOUT in package cache_types, alongside NUM_CACHE.
REQ-028 SHALL place the circular priority pick (req, ptr -> winner index, valid) in combinational sub-module rr_pick; all other logic lives in snoop_arbiter.
REQ-029 SHALL include assertions for gnt $onehot0, gnt implies a GRANT-state cycle, and busy == (state != IDLE).

Verification
REQ-030 SHALL cover: after reset, req=4'b1111 held, done pulsed 1 cycle after each gnt -> gnt sequence 0001,0010,0100,1000,0001.
REQ-031 SHALL cover: req=4'b0100 only, repeated done -> every gnt = 0100, owner = 2, gnt 1 cycle after IDLE sampling.
REQ-032 SHALL cover: grant node 1, then withhold done for TIMEOUT cycles -> timeout = 1, state IDLE; timeout stays 1 after later successful grants.
REQ-033 SHALL cover: done and the counter reaching TIMEOUT in the same cycle -> timeout stays 0 and state goes to IDLE.
REQ-034 SHALL cover: rst asserted in WAIT with req=4'b1000 pending -> next cycle gnt = 0, busy = 0; the first grant after reset goes to node 3, the lowest set index after ptr = NUM_NODES-1.
REQ-035 SHALL cover: req=4'b1010 with ptr = 1 -> gnt = 1000, then ptr = 3 -> gnt = 0010.

Source files
------------

// File: rtl/cache_types.sv
// Shared cache-coherence types and constants for the snoop bus arbiter.
package cache_types;

  localparam int unsigned NUM_CACHE     = 4;
  localparam int unsigned SNOOP_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: first set req bit strictly after ptr, wrapping round.
module rr_pick
  import cache_types::*;
#(
  parameter int unsigned NUM_NODES = NUM_CACHE
) (
  input  logic [NUM_NODES-1:0]         req,
  input  logic [$clog2(NUM_NODES)-1:0] ptr,
  output logic [$clog2(NUM_NODES)-1:0] winner_c,
  output logic                         valid_c
);

  localparam int unsigned IDX_W = $clog2(NUM_NODES);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest hit after ptr is the one kept.
  always_comb begin
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = '0;
    for (int unsigned i = NUM_NODES; i >= 1; i--) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_NODES);
      if (req[idx]) begin
        winner_c = idx;
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_arbiter.sv
// Round-robin snoop bus arbiter: one-cycle grant pulse, wait for done or time out.
module snoop_arbiter
  import cache_types::*;
#(
  parameter int unsigned NUM_NODES = NUM_CACHE,
  parameter int unsigned TIMEOUT   = SNOOP_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NODES-1:0]         req,
  input  logic                         done,
  output logic [NUM_NODES-1:0]         gnt,
  output logic                         busy,
  output logic [$clog2(NUM_NODES)-1:0] owner,
  output logic                         timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_NODES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_NODES-1:0] gnt_d;
  logic [IDX_W-1:0] owner_d;
  logic             timeout_d;
  logic             busy_d;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;

  rr_pick #(.NUM_NODES(NUM_NODES)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .winner_c (pick_winner),
    .valid_c  (pick_valid)
  );

  // State and registered outputs; ptr resets to the last node so node 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_NODES - 1);
      cnt_q   <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
      owner   <= owner_d;
      timeout <= timeout_d;
    end
  end

  // Next state; the grant pulse is launched on the IDLE->GRANT transition.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    owner_d   = owner;
    timeout_d = timeout;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = NUM_NODES'(1) << pick_winner;
          owner_d = pick_winner;
          ptr_d   = pick_winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        state_d = done ? IDLE : WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Done on the same cycle wins, so expiry is only checked here.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt));
      assert ((gnt == '0) || (state_q == GRANT));
      assert (busy == (state_q != IDLE));
    end
  end

endmodule

// File: tb/tb_snoop_arbiter.sv
// Directed table-driven bench for snoop_arbiter (4 nodes, timeout 8).
module tb_snoop_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;
  } vec_t;

  vec_t vecs[$];

  snoop_arbiter #(.NUM_NODES(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one clock edge, then check the registered outputs.
  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic [3:0] eg, input logic eb, input logic [1:0] eo,
                      input logic et, input string tag);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
    cmp({tag, ".gnt"},     gnt,            eg);
    cmp({tag, ".busy"},    {3'b0, busy},    {3'b0, eb});
    cmp({tag, ".owner"},   {2'b0, owner},   {2'b0, eo});
    cmp({tag, ".timeout"}, {3'b0, timeout}, {3'b0, et});
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                              input logic [3:0] eg, input logic eb, input logic [1:0] eo,
                              input logic et);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.gnt = eg; v.busy = eb; v.owner = eo; v.timeout = et;
    vecs.push_back(v);
  endfunction

  initial begin
    // reset
    add(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
    // all requesting, done one cycle after each gnt: 0,1,2,3,0
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd0, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b1111, 0, 4'b0100, 1, 2'd2, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd2, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 2'd2, 0);
    add(0, 4'b1111, 0, 4'b1000, 1, 2'd3, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd3, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 2'd3, 0);
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 0);
    // lone requester 2, including done during GRANT and done ignored in IDLE
    add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
    add(0, 4'b0100, 0, 4'b0000, 1, 2'd2, 0);
    add(0, 4'b0100, 1, 4'b0000, 0, 2'd2, 0);
    add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
    add(0, 4'b0100, 1, 4'b0000, 0, 2'd2, 0);
    add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 0);
    // ptr to 1, then req 1010 -> 3 then 1
    add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b1010, 0, 4'b1000, 1, 2'd3, 0);
    add(0, 4'b1010, 1, 4'b0000, 0, 2'd3, 0);
    add(0, 4'b1010, 0, 4'b0010, 1, 2'd1, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].busy,
           vecs[i].owner, vecs[i].timeout, $sformatf("vec%0d", i));
    end

    // timeout: grant node 1 (ptr=1 wraps round to 1), withhold done
    step(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0, "to_gnt");
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 0, "to_wait");
    for (int k = 1; k < TO; k++)
      step(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 0, $sformatf("to_hold%0d", k));
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd1, 1, "to_expire");
    step(0, 4'b0001, 0, 4'b0001, 1, 2'd0, 1, "to_sticky_gnt");
    step(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 1, "to_sticky_done");

    // done on the expiry cycle wins
    step(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, "race_rst");
    step(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0, "race_gnt");
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 0, "race_wait");
    for (int k = 1; k < TO; k++)
      step(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 0, $sformatf("race_hold%0d", k));
    step(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 0, "race_done");
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, "race_idle");

    // reset in WAIT with node 3 pending, then reset in GRANT
    step(0, 4'b0001, 0, 4'b0001, 1, 2'd0, 0, "rw_gnt");
    step(0, 4'b1000, 0, 4'b0000, 1, 2'd0, 0, "rw_wait");
    step(1, 4'b1000, 1, 4'b0000, 0, 2'd0, 0, "rw_rst");
    step(0, 4'b1000, 0, 4'b1000, 1, 2'd3, 0, "rw_first");
    step(1, 4'b1000, 0, 4'b0000, 0, 2'd0, 0, "rg_rst");
    step(0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0, "rg_first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
